// File: rtl/spmv_rowptr_builder.sv
// Builds the 17-entry CSR row-pointer vector from a non-decreasing stream of
// nonzero row indices; empty rows (including trailing ones) are back-filled.
module spmv_rowptr_builder (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_valid,
  input  logic [3:0]   i_row,
  input  logic         i_eom,
  output logic         o_ready,
  output logic [135:0] o_row_ptr,
  output logic [7:0]   o_nnz,
  output logic         o_valid,
  output logic         o_done,
  output logic         o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FILL,
    S_TAIL,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  ptr_q [17];
  logic [7:0]  nnz_q, nnz_d;
  logic [4:0]  cur_row_q, cur_row_d;
  logic [4:0]  tgt_q, tgt_d;
  logic        eom_pend_q, eom_pend_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        wr_en;
  logic        clr_ptr;
  logic        enter_fill;

  logic [4:0]  row_ext;
  logic [4:0]  cur_inc;
  logic        nnz_full;

  assign row_ext  = {1'b0, i_row};
  assign cur_inc  = cur_row_q + 5'd1;
  assign nnz_full = (nnz_q == 8'hFF);

  // Every pointer write lands at cur_row+1 and stores the pre-increment nnz.
  always_comb begin
    state_d    = state_q;
    nnz_d      = nnz_q;
    cur_row_d  = cur_row_q;
    tgt_d      = tgt_q;
    eom_pend_d = eom_pend_q;
    err_d      = err_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    clr_ptr    = 1'b0;
    enter_fill = 1'b0;

    if (i_start) begin
      state_d    = S_ACCUM;
      nnz_d      = 8'd0;
      cur_row_d  = 5'd0;
      tgt_d      = 5'd0;
      eom_pend_d = 1'b0;
      err_d      = 1'b0;
      clr_ptr    = 1'b1;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (i_valid) begin
            if (row_ext < cur_row_q) begin
              err_d = 1'b1;
            end else if (row_ext == cur_row_q) begin
              if (nnz_full) err_d = 1'b1;
              else          nnz_d = nnz_q + 8'd1;
            end else begin
              wr_en     = 1'b1;
              cur_row_d = cur_inc;
              if (row_ext == cur_inc) begin
                if (nnz_full) err_d = 1'b1;
                else          nnz_d = nnz_q + 8'd1;
              end else begin
                // Larger gap: the element is counted at the end of FILL.
                tgt_d      = row_ext;
                eom_pend_d = i_eom;
                enter_fill = 1'b1;
                state_d    = S_FILL;
              end
            end
          end
          if (i_eom && !enter_fill) state_d = S_TAIL;
        end

        S_FILL: begin
          wr_en     = 1'b1;
          cur_row_d = cur_inc;
          if (cur_inc == tgt_q) begin
            if (nnz_full) err_d = 1'b1;
            else          nnz_d = nnz_q + 8'd1;
            state_d    = eom_pend_q ? S_TAIL : S_ACCUM;
            eom_pend_d = 1'b0;
          end
        end

        S_TAIL: begin
          if (cur_row_q < 5'd16) begin
            wr_en     = 1'b1;
            cur_row_d = cur_inc;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      nnz_q      <= 8'd0;
      cur_row_q  <= 5'd0;
      tgt_q      <= 5'd0;
      eom_pend_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      for (int k = 0; k < 17; k++) ptr_q[k] <= 8'd0;
    end else begin
      state_q    <= state_d;
      nnz_q      <= nnz_d;
      cur_row_q  <= cur_row_d;
      tgt_q      <= tgt_d;
      eom_pend_q <= eom_pend_d;
      err_q      <= err_d;
      done_q     <= done_d;
      if (clr_ptr) begin
        for (int k = 0; k < 17; k++) ptr_q[k] <= 8'd0;
      end else if (wr_en) begin
        ptr_q[cur_inc] <= nnz_q;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 17; gi++) begin : g_pack
      assign o_row_ptr[8*gi +: 8] = ptr_q[gi];
    end
  endgenerate

  assign o_ready = (state_q == S_ACCUM);
  assign o_valid = (state_q == S_DONE);
  assign o_done  = done_q;
  assign o_err   = err_q;
  assign o_nnz   = nnz_q;

endmodule

// File: doc/spmv_rowptr_builder.md
# spmv_rowptr_builder

Builds the CSR row-pointer vector for the SpMV engine from a row-major stream of nonzero row indices. This is the writer side of the row-pointer interface: it produces the packed 17-entry, 8-bit `row_ptr` vector that the SpMV comparator reads back to map a nonzero index to its row. The block sits between the matrix loader and the comparator. It counts nonzeros per row and fills pointers for empty rows, including trailing ones. It flags out-of-order or overflowing input.

## Interface
- No parameters. The vector has 16 rows, 17 pointer entries and 8-bit pointers, all fixed.
- `i_clk`  in  1  Clock. Everything is on the rising edge.
- `i_rst`  in  1  Synchronous, active-high reset.
- `i_start`  in  1  Clears all state and begins a new matrix. Accepted in any state.
- `i_valid`  in  1  Nonzero element present on `i_row`.
- `i_row`  in  4  Row index of the element. Must be non-decreasing within a matrix.
- `i_eom`  in  1  End of matrix. Accepted only when `o_ready` is high.
- `o_ready`  out  1  Element/EOM accept. Equals (state == ACCUM).
- `o_row_ptr`  out  136  Entry k is at bits [8k+7:8k]. Entry 0 is always 0.
- `o_nnz`  out  8  Nonzeros counted so far.
- `o_valid`  out  1  Level signal: `o_row_ptr` is complete.
- `o_done`  out  1  One-cycle pulse on entry to DONE.
- `o_err`  out  1  Sticky error flag. Cleared only by `i_start` or `i_rst`.

## Operation
- **Registers**
  - `ptr[0..16]`, each 8 bits.
  - `nnz`, 8 bits.
  - `cur_row`, 5 bits: the row currently being counted.
  - `tgt`, 5 bits.
  - `eom_pend`, 1 bit.
  - `state`.
- **States:** IDLE, ACCUM, FILL, TAIL, DONE.
- **IDLE**
  - `o_ready` = 0.
  - `i_start` → clear `ptr`, `nnz`, `cur_row`, `o_err` and `eom_pend`, then go to ACCUM.
- **ACCUM**, element accepted (`i_valid` & `o_ready`) with row r:
  - r == `cur_row`: `nnz` += 1.
  - r == `cur_row`+1: `ptr[cur_row+1]` ← `nnz`; `cur_row` += 1; `nnz` += 1.
  - r > `cur_row`+1: `ptr[cur_row+1]` ← `nnz`; `cur_row` += 1; `tgt` ← r; go to FILL.
  - r < `cur_row`: set `o_err` and drop the element. State is unchanged.
  - `nnz` == 255 on accept: set `o_err` and drop the element (no wrap). Fill writes for that element still happen.
- **FILL** (`o_ready` = 0), once per cycle:
  - `ptr[cur_row+1]` ← `nnz`; `cur_row` += 1.
  - When `cur_row`+1 == `tgt`: also `nnz` += 1, then go to TAIL if `eom_pend`, else ACCUM.
  - An element with gap g = r − `cur_row` therefore stalls `o_ready` for g−1 cycles.
- **EOM**
  - `i_eom` accepted in ACCUM → go to TAIL.
  - If `i_eom` arrives together with an element, the element is processed first.
  - If that element enters FILL, set `eom_pend`; TAIL follows FILL.
- **TAIL**
  - While `cur_row` < 16: `ptr[cur_row+1]` ← `nnz`; `cur_row` += 1, one entry per cycle.
  - When `cur_row` == 16, go to DONE. No write is made in that cycle.
- **DONE**
  - `o_valid` = 1 and is held.
  - `o_done` pulses high on the first DONE cycle only.
  - Inputs other than `i_start` are ignored.
- **Priority:** `i_rst` > `i_start` > normal operation.
  - `i_start` during ACCUM, FILL or TAIL aborts the matrix. It clears state the same way as from IDLE and goes to ACCUM.
- **Invariant:** `ptr[k]` ≤ `ptr[k+1]`. In DONE, `ptr[16]` == `o_nnz`.

## Timing
- **Reset values:** `o_row_ptr` = 0, `o_nnz` = 0, `o_ready` = 0, `o_valid` = 0, `o_done` = 0, `o_err` = 0, state = IDLE.
- All outputs are registered or decoded from state; there is no input-to-output combinational path.
- `o_ready` rises the cycle after `i_start`.
- Latency from `i_eom` acceptance to `o_done` is (16 − `cur_row`) + 1 cycles.
  - Example: `i_eom` accepted at `cur_row` 15 → one TAIL write cycle, then the DONE cycle with `o_done` = 1.
- `o_row_ptr` updates the cycle after each write. Intermediate values are visible but are valid only while `o_valid` = 1.

## Test plan
- **Reference matrix:** reset, `i_start`, then stream rows 1,2,4,5,8,8,8,12,12,15 and EOM → `o_row_ptr` = 136'h0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00, `o_nnz` = 10, one `o_done` pulse, `o_err` = 0.
- **Empty matrix:** `i_start` then `i_eom` at once → 16 TAIL cycles, then `o_done`; all entries 0.
- **Stall check:** at `cur_row` 0, send an element with row 9 → `o_ready` low for exactly 8 cycles; `ptr[1..9]` = 0, `nnz` = 1. EOM in the same cycle → DONE with `ptr[10..16]` = 1.
- **Order error:** rows 3 then 2 → `o_err` set and held; the row-2 element is not counted (`o_nnz` = 1).
- **Overflow:** send 256 row-0 elements → `o_nnz` stays 255 and `o_err` = 1.
- **Abort:** `i_rst` mid-FILL → all outputs return to reset values and state is IDLE. `i_start` mid-TAIL → restart, `o_row_ptr` = 0, `o_ready` = 1 next cycle.
